// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit: latches one request, computes in EXEC (or
// nibble-serially in BCD for DADD), then presents registered result/flags in DONE.
module alu_exec_unit #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic                 byte_mode,
  input  logic [WORD_SIZE-1:0] dst_in,
  input  logic [WORD_SIZE-1:0] src_in,
  input  logic                 carry_in,
  output logic [WORD_SIZE-1:0] result,
  output logic [3:0]           flags,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_en,
  output logic                 flags_we
);

  localparam int NIB   = WORD_SIZE / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDC = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBC = 4'h3;
  localparam logic [3:0] OP_DADD = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_BIT  = 4'h8;
  localparam logic [3:0] OP_BIC  = 4'h9;
  localparam logic [3:0] OP_BIS  = 4'hA;
  localparam logic [3:0] OP_MOV  = 4'hB;
  localparam logic [3:0] OP_SRA  = 4'hC;
  localparam logic [3:0] OP_RRC  = 4'hD;
  localparam logic [3:0] OP_SWPB = 4'hE;
  localparam logic [3:0] OP_SXT  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_BCD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic                 byte_q, byte_d;
  logic [WORD_SIZE-1:0] dst_q, dst_d;
  logic [WORD_SIZE-1:0] src_q, src_d;
  logic                 cin_q, cin_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic [WORD_SIZE-1:0] acc_q, acc_d;
  logic                 bc_q, bc_d;
  logic [NIB_W-1:0]     nib_q, nib_d;

  // ---------------- single-cycle datapath ----------------
  logic [WORD_SIZE-1:0] b_eff;
  logic                 c_eff;
  logic [WORD_SIZE:0]   sum_w;
  logic [8:0]           sum_b;
  logic [WORD_SIZE-1:0] alu_res;
  logic                 alu_c, alu_v, alu_n, alu_z, byte_op;
  logic                 a_m, b_m;

  always_comb begin
    b_eff = src_q;
    c_eff = 1'b0;
    case (op_q)
      OP_ADDC:        c_eff = cin_q;
      OP_SUB, OP_CMP: begin b_eff = ~src_q; c_eff = 1'b1;  end
      OP_SUBC:        begin b_eff = ~src_q; c_eff = cin_q; end
      default:        ;
    endcase
  end

  assign sum_w = {1'b0, dst_q} + {1'b0, b_eff} + {{WORD_SIZE{1'b0}}, c_eff};
  assign sum_b = {1'b0, dst_q[7:0]} + {1'b0, b_eff[7:0]} + {8'b0, c_eff};

  always_comb begin
    byte_op = byte_q && (op_q != OP_SWPB) && (op_q != OP_SXT);
    alu_res = dst_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    a_m     = byte_q ? dst_q[7] : dst_q[WORD_SIZE-1];
    b_m     = byte_q ? b_eff[7] : b_eff[WORD_SIZE-1];
    case (op_q)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        alu_res = sum_w[WORD_SIZE-1:0];
        alu_c   = byte_q ? sum_b[8] : sum_w[WORD_SIZE];
      end
      OP_XOR:         alu_res = dst_q ^ src_q;
      OP_AND, OP_BIT: alu_res = dst_q & src_q;
      OP_BIC:         alu_res = dst_q & ~src_q;
      OP_BIS:         alu_res = dst_q | src_q;
      OP_MOV:         alu_res = src_q;
      OP_SRA: begin
        alu_res = {dst_q[WORD_SIZE-1], dst_q[WORD_SIZE-1:1]};
        if (byte_q) alu_res[7:0] = {dst_q[7], dst_q[7:1]};
        alu_c = dst_q[0];
      end
      OP_RRC: begin
        alu_res = {cin_q, dst_q[WORD_SIZE-1:1]};
        if (byte_q) alu_res[7:0] = {cin_q, dst_q[7:1]};
        alu_c = dst_q[0];
      end
      OP_SWPB: alu_res = {dst_q[7:0], dst_q[WORD_SIZE-1:8]};
      OP_SXT:  alu_res = {{(WORD_SIZE-8){dst_q[7]}}, dst_q[7:0]};
      default: ;
    endcase
    // Byte ops pass the destination's upper byte through untouched
    if (byte_op) alu_res[WORD_SIZE-1:8] = dst_q[WORD_SIZE-1:8];
    alu_n = byte_op ? alu_res[7] : alu_res[WORD_SIZE-1];
    alu_z = byte_op ? (alu_res[7:0] == 8'd0) : (alu_res == '0);
    case (op_q)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: alu_v = (a_m == b_m) && (alu_n != a_m);
      default: ;
    endcase
  end

  // ---------------- nibble-serial BCD adder ----------------
  logic [3:0]           dst_nib [NIB];
  logic [3:0]           src_nib [NIB];
  logic [4:0]           bcd_t;
  logic                 bcd_carry, bcd_last, bcd_n, bcd_z;
  logic [3:0]           bcd_nib;
  logic [WORD_SIZE-1:0] bcd_word;

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign dst_nib[gi] = dst_q[gi*4 +: 4];
      assign src_nib[gi] = src_q[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    bcd_t     = {1'b0, dst_nib[nib_q]} + {1'b0, src_nib[nib_q]} + {4'b0, bc_q};
    bcd_carry = (bcd_t > 5'd9);
    bcd_nib   = bcd_carry ? (bcd_t[3:0] + 4'd6) : bcd_t[3:0];
    bcd_word  = acc_q;
    for (int i = 0; i < NIB; i++) begin
      if (nib_q == NIB_W'(i)) bcd_word[i*4 +: 4] = bcd_nib;
    end
    bcd_last = (nib_q == (byte_q ? NIB_W'(1) : NIB_W'(NIB - 1)));
    bcd_n    = byte_q ? bcd_word[7] : bcd_word[WORD_SIZE-1];
    bcd_z    = byte_q ? (bcd_word[7:0] == 8'd0) : (bcd_word == '0);
  end

  // ---------------- control FSM ----------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    byte_d   = byte_q;
    dst_d    = dst_q;
    src_d    = src_q;
    cin_d    = cin_q;
    result_d = result_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
    bc_d     = bc_q;
    nib_d    = nib_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          byte_d  = byte_mode;
          dst_d   = dst_in;
          src_d   = src_in;
          cin_d   = carry_in;
          acc_d   = dst_in;
          bc_d    = carry_in;
          nib_d   = '0;
          state_d = (op == OP_DADD) ? S_BCD : S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q != OP_CMP && op_q != OP_BIT) result_d = alu_res;
        if (op_q != OP_MOV) flags_d = {alu_v, alu_n, alu_z, alu_c};
        state_d = S_DONE;
      end
      S_BCD: begin
        acc_d = bcd_word;
        bc_d  = bcd_carry;
        nib_d = nib_q + NIB_W'(1);
        if (bcd_last) begin
          result_d = bcd_word;
          flags_d  = {1'b0, bcd_n, bcd_z, bcd_carry};
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 4'h0;
      byte_q   <= 1'b0;
      dst_q    <= '0;
      src_q    <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'h0;
      acc_q    <= '0;
      bc_q     <= 1'b0;
      nib_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      byte_q   <= byte_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
      bc_q     <= bc_d;
      nib_q    <= nib_d;
    end
  end

  assign result   = result_q;
  assign flags    = flags_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign wr_en    = done && (op_q != OP_CMP) && (op_q != OP_BIT);
  assign flags_we = done && (op_q != OP_MOV);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, latency, qualifiers,
// start-while-busy, and mid-operation reset.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic        byte_mode;
  logic [15:0] dst_in, src_in;
  logic        carry_in;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        busy, done, wr_en, flags_we;

  int checks_total  = 0;
  int checks_passed = 0;

  alu_exec_unit #(.WORD_SIZE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .byte_mode(byte_mode),
    .dst_in   (dst_in),
    .src_in   (src_in),
    .carry_in (carry_in),
    .result   (result),
    .flags    (flags),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .flags_we (flags_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else checks_passed++;
  endtask

  // Drive one request at a negedge, wait for done (bounded), check everything.
  task automatic run_op(input string name, input logic [3:0] o, input logic bm,
                        input logic [15:0] d, input logic [15:0] s, input logic c,
                        input logic [15:0] exp_res, input logic [3:0] exp_flg,
                        input int exp_lat);
    int cyc;
    @(negedge clk);
    op = o; byte_mode = bm; dst_in = d; src_in = s; carry_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dst_in = 16'hDEAD; src_in = 16'hBEEF; op = 4'h0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 12) begin
      chk({name, "_busy"}, {31'b0, busy}, 32'd1);
      @(negedge clk);
      cyc++;
    end
    chk({name, "_lat"},   cyc, exp_lat);
    chk({name, "_res"},   {16'b0, result}, {16'b0, exp_res});
    chk({name, "_flags"}, {28'b0, flags}, {28'b0, exp_flg});
    chk({name, "_wr"},    {31'b0, wr_en},    {31'b0, (o != 4'h5 && o != 4'h8)});
    chk({name, "_fwe"},   {31'b0, flags_we}, {31'b0, (o != 4'hB)});
    @(negedge clk);
    chk({name, "_done1"}, {31'b0, done}, 32'd0);
    chk({name, "_idle"},  {31'b0, busy}, 32'd0);
    $display("op %s d=%h s=%h cin=%0d bm=%0d -> res=%h flags=%b lat=%0d",
             name, d, s, c, bm, result, flags, cyc);
  endtask

  initial begin
    int cyc;
    int done_seen;
    rst = 1'b1; start = 1'b0; op = 4'h0; byte_mode = 1'b0;
    dst_in = 16'h0; src_in = 16'h0; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_res",   {16'b0, result}, 32'd0);
    chk("rst_flags", {28'b0, flags}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_done",  {31'b0, done}, 32'd0);
    chk("rst_wr",    {31'b0, wr_en}, 32'd0);
    chk("rst_fwe",   {31'b0, flags_we}, 32'd0);
    rst = 1'b0;

    //     name     op    bm    dst       src       cin   result    {V,N,Z,C} lat
    run_op("ADD",   4'h0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1100, 2);
    run_op("DADDw", 4'h4, 1'b0, 16'h0999, 16'h0001, 1'b0, 16'h1000, 4'b0000, 5);
    run_op("ADDb",  4'h0, 1'b1, 16'hAB80, 16'h0080, 1'b0, 16'hAB00, 4'b1011, 2);
    run_op("CMP",   4'h5, 1'b0, 16'h0005, 16'h0005, 1'b0, 16'hAB00, 4'b0011, 2);
    run_op("RRC",   4'hD, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h8000, 4'b0101, 2);
    run_op("MOV",   4'hB, 1'b0, 16'h5555, 16'h1234, 1'b0, 16'h1234, 4'b0101, 2);
    run_op("BIT",   4'h8, 1'b0, 16'h00F0, 16'h0F00, 1'b0, 16'h1234, 4'b0010, 2);
    run_op("DADDb", 4'h4, 1'b1, 16'h1299, 16'h0001, 1'b0, 16'h1200, 4'b0011, 3);
    run_op("SUB",   4'h2, 1'b0, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 4'b0100, 2);
    run_op("SUBv",  4'h2, 1'b0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b1001, 2);
    run_op("ADDC",  4'h1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b0011, 2);
    run_op("SUBC",  4'h3, 1'b0, 16'h0005, 16'h0003, 1'b0, 16'h0001, 4'b0001, 2);
    run_op("SXT",   4'hF, 1'b1, 16'h0080, 16'h0000, 1'b0, 16'hFF80, 4'b0100, 2);
    run_op("SWPB",  4'hE, 1'b1, 16'h1234, 16'h0000, 1'b0, 16'h3412, 4'b0000, 2);
    run_op("SRAb",  4'hC, 1'b1, 16'h5581, 16'h0000, 1'b0, 16'h55C0, 4'b0101, 2);
    run_op("BIC",   4'h9, 1'b0, 16'hFFFF, 16'h00FF, 1'b0, 16'hFF00, 4'b0100, 2);
    run_op("XORb",  4'h6, 1'b1, 16'h12FF, 16'h000F, 1'b0, 16'h12F0, 4'b0100, 2);
    run_op("BIS",   4'hA, 1'b0, 16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 4'b0000, 2);
    run_op("AND",   4'h7, 1'b0, 16'hFF00, 16'h0FF0, 1'b0, 16'h0F00, 4'b0000, 2);

    // Second start during a DADD must be ignored: no re-latch, single done.
    @(negedge clk);
    op = 4'h4; byte_mode = 1'b0; dst_in = 16'h0999; src_in = 16'h0001; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 4'h0; dst_in = 16'h1111; src_in = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (done !== 1'b1 && cyc < 12) begin @(negedge clk); cyc++; end
    chk("ign_lat", cyc, 32'd5);
    chk("ign_res", {16'b0, result}, 32'h1000);
    done_seen = 0;
    repeat (6) begin @(negedge clk); if (done === 1'b1) done_seen++; end
    chk("ign_no2nd", done_seen, 32'd0);
    $display("start-while-busy: res=%h lat=%0d extra_done=%0d", result, cyc, done_seen);

    // Reset in the second BCD cycle aborts the operation.
    op = 4'h4; dst_in = 16'h0999; src_in = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_res",   {16'b0, result}, 32'd0);
    chk("abort_flags", {28'b0, flags}, 32'd0);
    chk("abort_busy",  {31'b0, busy}, 32'd0);
    chk("abort_done",  {31'b0, done}, 32'd0);
    chk("abort_wr",    {31'b0, wr_en}, 32'd0);
    chk("abort_fwe",   {31'b0, flags_we}, 32'd0);
    done_seen = 0;
    repeat (8) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) done_seen++; end
    chk("abort_quiet", done_seen, 32'd0);
    $display("mid-op reset: res=%h flags=%b busy=%0d done=%0d", result, flags, busy, done);

    // Reset wins over a simultaneous start.
    run_op("ADD2", 4'h0, 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000, 2);
    @(negedge clk);
    op = 4'h0; dst_in = 16'h0003; src_in = 16'h0004; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rstprio_busy", {31'b0, busy}, 32'd0);
    chk("rstprio_res",  {16'b0, result}, 32'd0);
    $display("rst+start: busy=%0d res=%h", busy, result);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
